// File: rtl/mips_mc.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB controller around one ALU,
// with a single req/ready memory port shared by instruction and data traffic.
module mips_mc #(
    parameter logic [31:0] RESET_PC        = 32'h0000_3000,
    parameter bit          OVF_TRAP        = 1'b1,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_o,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        retire,
    output logic        halted
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]  state;
    logic        run;
    logic [31:0] pc, npc, ir, a_reg, b_reg, alu_out, mdr;
    logic        ovf_q;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] simm, zimm, rs_val, rt_val, jmp_tgt, br_tgt;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign imm   = ir[15:0];
    assign idx   = ir[25:0];
    assign simm  = {{16{imm[15]}}, imm};
    assign zimm  = {16'h0000, imm};

    logic special, is_addu, is_subu, is_add, is_slt, is_jr, is_brk;
    logic is_addi, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, legal;

    assign special = (op == 6'h00);
    assign is_addu = special && (funct == 6'h21);
    assign is_subu = special && (funct == 6'h23);
    assign is_add  = special && (funct == 6'h20);
    assign is_slt  = special && (funct == 6'h2A);
    assign is_jr   = special && (funct == 6'h08);
    assign is_brk  = special && (funct == 6'h0D);
    assign is_addi = (op == 6'h08);
    assign is_ori  = (op == 6'h0D);
    assign is_lui  = (op == 6'h0F);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);
    assign is_jal  = (op == 6'h03);
    assign legal   = is_addu | is_subu | is_add | is_slt | is_jr | is_addi | is_ori |
                     is_lui | is_lw | is_sw | is_beq | is_j | is_jal;

    assign rs_val  = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rt_val  = (rt == 5'd0) ? 32'd0 : rf[rt];
    assign jmp_tgt = {npc[31:28], idx, 2'b00};
    assign br_tgt  = npc + (simm << 2);

    // Shared ALU: R-type uses rt, ori zero-extends, everything else sign-extends.
    logic [31:0] alu_b, alu_sum, alu_res;
    logic        alu_ovf;
    always_comb begin
        alu_b   = special ? b_reg : (is_ori ? zimm : simm);
        alu_sum = a_reg + alu_b;
        alu_ovf = (a_reg[31] == alu_b[31]) && (alu_sum[31] != a_reg[31]);
        alu_res = alu_sum;
        if (is_subu)     alu_res = a_reg - alu_b;
        else if (is_slt) alu_res = {31'd0, $signed(a_reg) < $signed(alu_b)};
        else if (is_ori) alu_res = a_reg | zimm;
        else if (is_lui) alu_res = {imm, 16'h0000};
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
        if (state == S_DECODE && is_jal) begin
            wb_en   = 1'b1;
            wb_addr = 5'd31;
            wb_data = npc;
        end else if (state == S_WB && !ovf_q) begin
            wb_en   = 1'b1;
            wb_addr = special ? rd : rt;
            wb_data = is_lw ? mdr : alu_out;
        end
    end

    // run keeps the first request off the reset-release cycle
    always_comb begin
        mem_req   = run && (state == S_FETCH || state == S_MEM);
        mem_we    = mem_req && (state == S_MEM) && is_sw;
        mem_addr  = 32'd0;
        if (mem_req)
            mem_addr = (state == S_FETCH) ? {pc[31:2], 2'b00} : {alu_out[31:2], 2'b00};
        mem_wdata = mem_we ? b_reg : 32'd0;
    end

    assign retire = (state == S_WB) ||
                    (state == S_MEM && mem_req && is_sw && mem_ready) ||
                    (state == S_EXEC && is_beq) ||
                    (state == S_DECODE && (is_j || is_jal || is_jr ||
                                           (!legal && !is_brk && !HALT_ON_ILLEGAL)));
    assign halted = (state == S_HALT);
    assign pc_o   = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wb_en && wb_addr != 5'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            run     <= 1'b0;
            pc      <= RESET_PC;
            npc     <= 32'd0;
            ir      <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
            ovf_q   <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                S_FETCH: if (run && mem_ready) begin
                    ir    <= mem_rdata;
                    npc   <= pc + 32'd4;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a_reg <= rs_val;
                    b_reg <= rt_val;
                    if (is_j || is_jal) begin
                        pc    <= jmp_tgt;
                        state <= S_FETCH;
                    end else if (is_jr) begin
                        pc    <= rs_val;
                        state <= S_FETCH;
                    end else if (is_brk) begin
                        state <= S_HALT;
                    end else if (!legal) begin
                        if (HALT_ON_ILLEGAL) state <= S_HALT;
                        else begin
                            pc    <= npc;
                            state <= S_FETCH;
                        end
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    ovf_q   <= OVF_TRAP && (is_add || is_addi) && alu_ovf;
                    if (is_beq) begin
                        pc    <= (a_reg == b_reg) ? br_tgt : npc;
                        state <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: if (mem_ready) begin
                    if (is_sw) begin
                        pc    <= npc;
                        state <= S_FETCH;
                    end else begin
                        mdr   <= mem_rdata;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc    <= npc;
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc.sv
// Bench for mips_mc: two cores (default params, and wrap/NOP variant) each on a
// wait-state memory model; dut0 writebacks are scoreboarded, dut1 writebacks logged.
module tb_mips_mc;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    localparam logic [31:0] BRK = 32'h0000_000D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req, we, rdy, wbe, ret, hlt;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic [31:0] pcv  [2];
    logic [31:0] wbd  [2];
    logic [4:0]  wba  [2];

    logic [31:0] mem [2][4096];
    int          wait_n [2];
    int          wc [2];
    int          ret_cnt [2];
    int          n_cmp = 0;
    int          n_err = 0;
    wb_t         exp0 [$];
    wb_t         log1 [$];
    logic [31:0] flog [$];
    logic [31:0] prog [$];

    always #5 clk = ~clk;

    mips_mc dut0 (
        .clk(clk), .rst(rst), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wdat[0]), .mem_rdata(rdat[0]), .mem_ready(rdy[0]), .pc_o(pcv[0]),
        .wb_en(wbe[0]), .wb_addr(wba[0]), .wb_data(wbd[0]), .retire(ret[0]), .halted(hlt[0])
    );

    mips_mc #(.OVF_TRAP(1'b0), .HALT_ON_ILLEGAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wdat[1]), .mem_rdata(rdat[1]), .mem_ready(rdy[1]), .pc_o(pcv[1]),
        .wb_en(wbe[1]), .wb_addr(wba[1]), .wb_data(wbd[1]), .retire(ret[1]), .halted(hlt[1])
    );

    // Memory responder: ready comes after wait_n stalled cycles of a request.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (req[k]) begin
                if (wc[k] >= wait_n[k]) begin
                    rdy[k]  = 1'b1;
                    rdat[k] = mem[k][addr[k][13:2]];
                    wc[k]   = 0;
                end else begin
                    rdy[k] = 1'b0;
                    wc[k]  = wc[k] + 1;
                end
            end else begin
                rdy[k] = 1'b0;
                wc[k]  = 0;
            end
        end
    end

    wb_t m_e, m_g;
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                if (req[k] && we[k] && rdy[k]) mem[k][addr[k][13:2]] = wdat[k];
                if (ret[k]) ret_cnt[k]++;
            end
            if (req[0] && rdy[0] && !we[0]) flog.push_back(addr[0]);
            if (wbe[1]) begin
                m_g.a = wba[1]; m_g.d = wbd[1];
                log1.push_back(m_g);
            end
            if (wbe[0]) begin
                n_cmp++;
                m_g.a = wba[0]; m_g.d = wbd[0];
                if (exp0.size() == 0) begin
                    n_err++;
                    $display("FAIL wb_scoreboard: got r%0d=%h, required no write", m_g.a, m_g.d);
                end else begin
                    m_e = exp0.pop_front();
                    if (m_g !== m_e) begin
                        n_err++;
                        $display("FAIL wb_scoreboard: got r%0d=%h, required r%0d=%h",
                                 m_g.a, m_g.d, m_e.a, m_e.d);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] r_op(input logic [5:0] f, input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction
    function automatic logic [31:0] i_op(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] im);
        return {o, s, t, im};
    endfunction
    function automatic logic [31:0] j_op(input logic [5:0] o, input logic [31:0] tgt);
        return {o, tgt[27:2]};
    endfunction

    task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
        wb_t e;
        e.a = a; e.d = d;
        exp0.push_back(e);
    endtask

    task automatic load_prog(input int k);
        for (int i = 0; i < prog.size(); i++) mem[k][12'hC00 + i] = prog[i];
    endtask

    task automatic do_reset(input int w0, input int w1);
        rst = 1'b0;
        wait_n[0] = w0; wait_n[1] = w1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4096; i++) mem[k][i] = 32'd0;
            mem[k][12'hC00] = BRK;
            ret_cnt[k] = 0;
        end
        exp0.delete(); log1.delete(); flog.delete();
        @(negedge clk);
    endtask

    task automatic release_rst;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_halt(input int k, input int budget);
        for (int c = 0; c < budget && !hlt[k]; c++) @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset(0, 0);
        #1;
        n_cmp++;
        if ({req[0], we[0], wbe[0], ret[0], hlt[0]} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b, required 00000", {req[0], we[0], wbe[0], ret[0], hlt[0]});
        end
        n_cmp++;
        if (addr[0] !== 32'd0 || wdat[0] !== 32'd0 || wba[0] !== 5'd0 || wbd[0] !== 32'd0) begin
            n_err++; $display("FAIL reset_bus: got addr=%h wdata=%h wba=%0d wbd=%h, required zeros",
                              addr[0], wdat[0], wba[0], wbd[0]);
        end
        n_cmp++;
        if (pcv[0] !== 32'h3000) begin n_err++; $display("FAIL reset_pc: got %h, required 00003000", pcv[0]); end
        release_rst();
        #1;
        n_cmp++;
        if (req[0] !== 1'b0) begin n_err++; $display("FAIL req_before_edge: got %b, required 0", req[0]); end
        @(negedge clk);
        n_cmp++;
        if (req[0] !== 1'b1 || addr[0] !== 32'h3000) begin
            n_err++; $display("FAIL first_fetch: got req=%b addr=%h, required 1/00003000", req[0], addr[0]);
        end
    endtask

    task automatic test_ori;
        int nreq;
        do_reset(0, 0);
        prog = '{i_op(6'h0D, 5'd0, 5'd1, 16'h1234), BRK};
        load_prog(0);
        expect_wb(5'd1, 32'h1234);
        release_rst();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                n_cmp++;
                if (wbe[0] !== 1'b0) begin n_err++; $display("FAIL ori_early_wb: got %b, required 0", wbe[0]); end
            end
            if (c == 4) begin
                n_cmp++;
                if (wbe[0] !== 1'b1 || ret[0] !== 1'b1 || wba[0] !== 5'd1 || wbd[0] !== 32'h1234) begin
                    n_err++; $display("FAIL ori_wb_cycle4: got en=%b ret=%b r%0d=%h, required 1/1/r1=00001234",
                                      wbe[0], ret[0], wba[0], wbd[0]);
                end
            end
        end
        wait_halt(0, 50);
        n_cmp++;
        if (hlt[0] !== 1'b1 || pcv[0] !== 32'h3004) begin
            n_err++; $display("FAIL brk_halt: got halted=%b pc=%h, required 1/00003004", hlt[0], pcv[0]);
        end
        nreq = 0;
        repeat (8) begin @(negedge clk); if (req[0]) nreq++; end
        n_cmp++;
        if (nreq != 0) begin n_err++; $display("FAIL halt_no_req: got %0d, required 0", nreq); end
    endtask

    task automatic test_sw_lw;
        int nst, bad;
        do_reset(3, 0);
        prog = '{i_op(6'h0D, 5'd0, 5'd1, 16'h1234), i_op(6'h2B, 5'd0, 5'd1, 16'h0004),
                 i_op(6'h23, 5'd0, 5'd2, 16'h0004), r_op(6'h21, 5'd2, 5'd0, 5'd3), BRK};
        load_prog(0);
        expect_wb(5'd1, 32'h1234); expect_wb(5'd2, 32'h1234); expect_wb(5'd3, 32'h1234);
        release_rst();
        nst = 0; bad = 0;
        for (int c = 0; c < 400 && !hlt[0]; c++) begin
            @(negedge clk);
            if (req[0] && we[0]) begin
                nst++;
                if (addr[0] !== 32'h4 || wdat[0] !== 32'h1234) bad++;
            end
        end
        n_cmp++;
        if (nst != 4 || bad != 0) begin
            n_err++; $display("FAIL sw_hold: got %0d cycles (%0d unstable), required 4 (0)", nst, bad);
        end
        n_cmp++;
        if (mem[0][1] !== 32'h1234) begin n_err++; $display("FAIL sw_mem: got %h, required 00001234", mem[0][1]); end
        n_cmp++;
        if (!hlt[0] || exp0.size() != 0) begin
            n_err++; $display("FAIL sw_lw_done: got halted=%b pending=%0d, required 1/0", hlt[0], exp0.size());
        end
    endtask

    task automatic test_latency;
        int rc [$];
        int lat [5] = '{2, 3, 4, 4, 5};
        int c;
        do_reset(0, 0);
        prog = '{i_op(6'h0D, 5'd0, 5'd1, 16'h0005), j_op(6'h02, 32'h3008), i_op(6'h04, 5'd0, 5'd0, 16'h0000),
                 r_op(6'h21, 5'd1, 5'd1, 5'd2), i_op(6'h2B, 5'd0, 5'd2, 16'h0008),
                 i_op(6'h23, 5'd0, 5'd3, 16'h0008), BRK};
        load_prog(0);
        expect_wb(5'd1, 32'd5); expect_wb(5'd2, 32'd10); expect_wb(5'd3, 32'd10);
        release_rst();
        c = 0;
        while (c < 200 && !hlt[0]) begin
            @(negedge clk); c++;
            if (ret[0]) rc.push_back(c);
        end
        n_cmp++;
        if (rc.size() != 6 || rc[0] != 4) begin
            n_err++; $display("FAIL retire_count: got %0d (first at %0d), required 6 (first at 4)",
                              rc.size(), (rc.size() > 0) ? rc[0] : -1);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (rc[i+1] - rc[i] != lat[i]) begin
                    n_err++; $display("FAIL latency_%0d: got %0d, required %0d", i, rc[i+1] - rc[i], lat[i]);
                end
            end
        end
        n_cmp++;
        if (exp0.size() != 0) begin n_err++; $display("FAIL latency_pending: got %0d, required 0", exp0.size()); end
    endtask

    task automatic test_branch;
        logic [31:0] ef [9] = '{32'h3000, 32'h3004, 32'h3008, 32'h3004, 32'h3008,
                                32'h300C, 32'h3010, 32'h3020, 32'h3014};
        do_reset(0, 0);
        prog = '{i_op(6'h0D, 5'd0, 5'd3, 16'h0001), i_op(6'h08, 5'd1, 5'd1, 16'h0001),
                 i_op(6'h04, 5'd1, 5'd3, 16'hFFFE), i_op(6'h08, 5'd0, 5'd4, 16'hFFFF),
                 j_op(6'h03, 32'h3020), BRK, BRK, BRK, r_op(6'h08, 5'd31, 5'd0, 5'd0)};
        load_prog(0);
        expect_wb(5'd3, 32'd1); expect_wb(5'd1, 32'd1); expect_wb(5'd1, 32'd2);
        expect_wb(5'd4, 32'hFFFF_FFFF); expect_wb(5'd31, 32'h3014);
        release_rst();
        wait_halt(0, 300);
        n_cmp++;
        if (flog.size() != 9) begin
            n_err++; $display("FAIL fetch_count: got %0d, required 9", flog.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_cmp++;
                if (flog[i] !== ef[i]) begin n_err++; $display("FAIL fetch_%0d: got %h, required %h", i, flog[i], ef[i]); end
            end
        end
        n_cmp++;
        if (!hlt[0] || pcv[0] !== 32'h3014 || exp0.size() != 0) begin
            n_err++; $display("FAIL branch_end: got halted=%b pc=%h pending=%0d, required 1/00003014/0",
                              hlt[0], pcv[0], exp0.size());
        end
    endtask

    task automatic test_ovf;
        wb_t e1 [10];
        do_reset(0, 0);
        prog = '{i_op(6'h0F, 5'd0, 5'd1, 16'h7FFF), i_op(6'h0D, 5'd1, 5'd1, 16'hFFFF),
                 i_op(6'h0D, 5'd0, 5'd2, 16'h0001), r_op(6'h20, 5'd1, 5'd2, 5'd3),
                 i_op(6'h08, 5'd1, 5'd4, 16'h0001), r_op(6'h23, 5'd0, 5'd2, 5'd5),
                 r_op(6'h2A, 5'd5, 5'd2, 5'd6), r_op(6'h2A, 5'd2, 5'd5, 5'd7),
                 i_op(6'h0D, 5'd0, 5'd0, 16'h0005), r_op(6'h21, 5'd0, 5'd0, 5'd8), BRK};
        load_prog(0); load_prog(1);
        expect_wb(5'd1, 32'h7FFF_0000); expect_wb(5'd1, 32'h7FFF_FFFF); expect_wb(5'd2, 32'd1);
        expect_wb(5'd5, 32'hFFFF_FFFF); expect_wb(5'd6, 32'd1); expect_wb(5'd7, 32'd0);
        expect_wb(5'd0, 32'd5); expect_wb(5'd8, 32'd0);
        e1 = '{'{5'd1, 32'h7FFF_0000}, '{5'd1, 32'h7FFF_FFFF}, '{5'd2, 32'd1}, '{5'd3, 32'h8000_0000},
               '{5'd4, 32'h8000_0000}, '{5'd5, 32'hFFFF_FFFF}, '{5'd6, 32'd1}, '{5'd7, 32'd0},
               '{5'd0, 32'd5}, '{5'd8, 32'd0}};
        release_rst();
        for (int c = 0; c < 400 && !(hlt[0] && hlt[1]); c++) @(negedge clk);
        n_cmp++;
        if (ret_cnt[0] != 10 || ret_cnt[1] != 10) begin
            n_err++; $display("FAIL ovf_retires: got %0d/%0d, required 10/10", ret_cnt[0], ret_cnt[1]);
        end
        n_cmp++;
        if (exp0.size() != 0 || log1.size() != 10) begin
            n_err++; $display("FAIL ovf_counts: got pending=%0d wrap_writes=%0d, required 0/10", exp0.size(), log1.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (log1[i] !== e1[i]) begin
                    n_err++; $display("FAIL wrap_wb_%0d: got r%0d=%h, required r%0d=%h", i, log1[i].a, log1[i].d, e1[i].a, e1[i].d);
                end
            end
        end
    endtask

    task automatic test_illegal;
        int nreq;
        do_reset(0, 0);
        prog = '{i_op(6'h0D, 5'd0, 5'd1, 16'h0007), 32'hFC00_0000, i_op(6'h0D, 5'd0, 5'd2, 16'h0009), BRK};
        load_prog(0); load_prog(1);
        expect_wb(5'd1, 32'd7);
        release_rst();
        for (int c = 0; c < 200 && !(hlt[0] && hlt[1]); c++) @(negedge clk);
        n_cmp++;
        if (!hlt[0] || pcv[0] !== 32'h3004 || ret_cnt[0] != 1) begin
            n_err++; $display("FAIL illegal_halt: got halted=%b pc=%h retires=%0d, required 1/00003004/1",
                              hlt[0], pcv[0], ret_cnt[0]);
        end
        n_cmp++;
        if (!hlt[1] || pcv[1] !== 32'h300C || ret_cnt[1] != 3 || log1.size() != 2) begin
            n_err++; $display("FAIL illegal_nop: got halted=%b pc=%h retires=%0d writes=%0d, required 1/0000300c/3/2",
                              hlt[1], pcv[1], ret_cnt[1], log1.size());
        end else begin
            n_cmp++;
            if (log1[1].a !== 5'd2 || log1[1].d !== 32'd9) begin
                n_err++; $display("FAIL nop_next: got r%0d=%h, required r2=00000009", log1[1].a, log1[1].d);
            end
        end
        nreq = 0;
        repeat (10) begin @(negedge clk); if (req[0]) nreq++; end
        n_cmp++;
        if (nreq != 0 || exp0.size() != 0) begin
            n_err++; $display("FAIL illegal_quiet: got req=%0d pending=%0d, required 0/0", nreq, exp0.size());
        end
    endtask

    task automatic test_reset_mid_sw;
        bit seen;
        do_reset(5, 0);
        prog = '{i_op(6'h0D, 5'd0, 5'd1, 16'h0055), i_op(6'h2B, 5'd0, 5'd1, 16'h0000), BRK};
        load_prog(0);
        expect_wb(5'd1, 32'h55);
        release_rst();
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (req[0] && we[0]) seen = 1;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL sw_never_issued: got 0, required 1"); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (req[0] !== 1'b0 || we[0] !== 1'b0) begin
            n_err++; $display("FAIL async_drop: got req=%b we=%b, required 0/0", req[0], we[0]);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mem[0][0] !== 32'd0 || exp0.size() != 0) begin
            n_err++; $display("FAIL store_abandoned: got mem=%h pending=%0d, required 0/0", mem[0][0], exp0.size());
        end
        wait_n[0] = 0;
        mem[0][12'hC00] = r_op(6'h21, 5'd1, 5'd0, 5'd3);
        mem[0][12'hC01] = BRK;
        expect_wb(5'd3, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req[0] !== 1'b1 || addr[0] !== 32'h3000) begin
            n_err++; $display("FAIL restart_fetch: got req=%b addr=%h, required 1/00003000", req[0], addr[0]);
        end
        wait_halt(0, 50);
        n_cmp++;
        if (!hlt[0] || exp0.size() != 0) begin
            n_err++; $display("FAIL gpr_cleared: got halted=%b pending=%0d, required 1/0", hlt[0], exp0.size());
        end
    endtask

    initial begin
        rdy = 2'b00;
        rdat[0] = 32'd0; rdat[1] = 32'd0;
        wc[0] = 0; wc[1] = 0;
        test_reset();
        test_ori();
        test_sw_lw();
        test_latency();
        test_branch();
        test_ovf();
        test_illegal();
        test_reset_mid_sw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
